// File: rtl/fsk4_modulator.sv
// Continuous-phase 4-FSK transmitter: 2-bit symbol -> one of four NCO tones -> signed sine samples.
// Latency: sym_load 1 clk after start/boundary; sample_out 1 clk after phase_acc, one sample per clock.
// Backpressure: none; free-running once started, stop honoured only at the next symbol boundary.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         asynchronous active-low reset
//   i_start         1-clk pulse, begins transmission (IDLE only)
//   i_stop          1-clk pulse, ends transmission at the next symbol boundary
//   i_data_in       symbol to send, sampled only at symbol boundaries
//   o_sym_load      1-clk pulse: i_data_in was just captured
//   o_busy          high while transmitting
//   o_sample_valid  o_sample_out carries a live sample
//   o_sample_out    signed sine sample (0 when not valid)
module fsk4_modulator #(
  parameter int          SYMBOL_CLKS = 100,
  parameter int          PHASE_W     = 16,
  parameter int          LUT_AW      = 6,
  parameter int          SAMPLE_W    = 8,
  parameter int unsigned FTW0        = 655,
  parameter int unsigned FTW1        = 1311,
  parameter int unsigned FTW2        = 1966,
  parameter int unsigned FTW3        = 2621
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [1:0]                 i_data_in,
  output logic                       o_sym_load,
  output logic                       o_busy,
  output logic                       o_sample_valid,
  output logic signed [SAMPLE_W-1:0] o_sample_out
);

  localparam int CNT_W = $clog2(SYMBOL_CLKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_CLKS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_boundary;
  logic [PHASE_W-1:0]         r_phase_acc;
  logic [CNT_W-1:0]           r_sym_cnt;
  logic [1:0]                 r_sym_reg;
  logic                       r_stop_pend;
  logic                       r_sym_load;
  logic                       r_busy;
  logic                       r_sample_valid;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic [PHASE_W-1:0]         w_ftw;
  logic signed [SAMPLE_W-1:0] w_lut;

  // First quarter of round(127*sin(2*pi*k/64)), k = 0..16; table sized for
  // the 64-entry, 8-bit configuration.
  function automatic logic signed [7:0] quarter(input logic [4:0] i);
    logic signed [7:0] q;
    case (i)
      5'd0:    q = 8'sd0;
      5'd1:    q = 8'sd12;
      5'd2:    q = 8'sd25;
      5'd3:    q = 8'sd37;
      5'd4:    q = 8'sd49;
      5'd5:    q = 8'sd60;
      5'd6:    q = 8'sd71;
      5'd7:    q = 8'sd81;
      5'd8:    q = 8'sd90;
      5'd9:    q = 8'sd98;
      5'd10:   q = 8'sd106;
      5'd11:   q = 8'sd112;
      5'd12:   q = 8'sd117;
      5'd13:   q = 8'sd122;
      5'd14:   q = 8'sd125;
      5'd15:   q = 8'sd126;
      default: q = 8'sd127;
    endcase
    return q;
  endfunction

  // Full cycle from quarter wave: second quarter mirrors the index,
  // second half negates the value.
  function automatic logic signed [7:0] sine_lut(input logic [5:0] idx);
    logic [4:0]        qi;
    logic signed [7:0] mag;
    qi  = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    mag = quarter(qi);
    return idx[5] ? -mag : mag;
  endfunction

  assign w_lut = sine_lut(r_phase_acc[PHASE_W-1 -: LUT_AW]);

  always_comb begin
    w_ftw = PHASE_W'(FTW0);
    case (r_sym_reg)
      2'd0:    w_ftw = PHASE_W'(FTW0);
      2'd1:    w_ftw = PHASE_W'(FTW1);
      2'd2:    w_ftw = PHASE_W'(FTW2);
      default: w_ftw = PHASE_W'(FTW3);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_boundary  = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_boundary = (r_sym_cnt == LAST_CNT);
        if (w_boundary && r_stop_pend) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_phase_acc <= '0;
      r_sym_cnt   <= '0;
      r_sym_reg   <= '0;
      r_stop_pend <= 1'b0;
      r_sym_load  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sym_load <= 1'b0;
      if (r_state == S_IDLE) begin
        // stop arriving with start is deliberately dropped here
        if (i_start) begin
          r_sym_reg   <= i_data_in;
          r_sym_cnt   <= '0;
          r_phase_acc <= '0;
          r_sym_load  <= 1'b1;
          r_busy      <= 1'b1;
          r_stop_pend <= 1'b0;
        end
      end else begin
        // phase keeps running across boundaries for continuous phase
        r_phase_acc <= r_phase_acc + w_ftw;
        r_sym_cnt   <= r_sym_cnt + CNT_W'(1);
        if (i_stop) r_stop_pend <= 1'b1;
        if (w_boundary) begin
          r_sym_cnt <= '0;
          if (!r_stop_pend) begin
            r_sym_reg  <= i_data_in;
            r_sym_load <= 1'b1;
          end else begin
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_phase_acc <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sample_valid <= 1'b0;
      r_sample       <= '0;
    end else begin
      r_sample_valid <= r_busy;
      r_sample       <= r_busy ? w_lut : '0;
    end
  end

  assign o_sym_load     = r_sym_load;
  assign o_busy         = r_busy;
  assign o_sample_valid = r_sample_valid;
  assign o_sample_out   = r_sample;

endmodule
